// File: rtl/mul_iter_param.sv
// mul_iter_param: iterative RV M-extension multiplier (MUL/MULH/MULHSU/MULHU)
// with configurable radix, a product-reuse shortcut and a synchronous kill.
`default_nettype none

module mul_iter_param #(
    parameter int XLEN     = 32,
    parameter int BPC      = 1,
    parameter int REUSE_EN = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    input  logic            kill,
    input  logic [1:0]      mulop,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            ready,
    output logic            busy
);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic       REUSE  = (REUSE_EN != 0);

    generate
        if (!((XLEN == 32 || XLEN == 64) && (BPC == 1 || BPC == 2 || BPC == 4) &&
              (XLEN % BPC == 0) && (REUSE_EN == 0 || REUSE_EN == 1))) begin : g_param_check
            $error("mul_iter_param: illegal XLEN/BPC/REUSE_EN combination");
        end
    endgenerate

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        PREP  = 5'b00010,
        CALC  = 5'b00100,
        READY = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0]   a_q, b_q, last_a, last_b, mulr;
    logic [1:0]        op_q;
    logic [2*XLEN-1:0] acc, mcand;
    logic              neg, last_sa, last_sb, reuse_valid, reused;

    logic              req_sa, req_sb, op_sa, op_sb, a_neg, b_neg, reuse_hit;
    logic [XLEN-1:0]   a_abs, b_abs, mulr_shift;
    logic [2*XLEN-1:0] partial, acc_signed;

    assign req_sa = mulop[0] ^ mulop[1];
    assign req_sb = (mulop == 2'b01);
    assign op_sa  = op_q[0] ^ op_q[1];
    assign op_sb  = (op_q == 2'b01);

    assign reuse_hit = REUSE && reuse_valid && (op_a == last_a) && (op_b == last_b) &&
                       ((mulop == OP_MUL) || ((req_sa == last_sa) && (req_sb == last_sb)));

    assign a_neg = op_sa & a_q[XLEN-1];
    assign b_neg = op_sb & b_q[XLEN-1];
    assign a_abs = a_neg ? (~a_q + 1'b1) : a_q;
    assign b_abs = b_neg ? (~b_q + 1'b1) : b_q;

    assign mulr_shift = mulr >> BPC;
    assign acc_signed = neg ? (~acc + 1'b1) : acc;
    assign busy       = (state != IDLE);

    // One radix digit of the multiplier as a sum of shifted multiplicands.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BPC; i++) begin
            if (mulr[i]) partial = partial + (mcand << i);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = reuse_hit ? READY : PREP;
            PREP:    state_next = (b_abs == '0) ? READY : CALC;
            CALC:    if (mulr_shift == '0) state_next = READY;
            READY:   state_next = DONE;
            DONE:    if (!valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            acc         <= '0;
            mcand       <= '0;
            mulr        <= '0;
            neg         <= 1'b0;
            last_a      <= '0;
            last_b      <= '0;
            last_sa     <= 1'b0;
            last_sb     <= 1'b0;
            reuse_valid <= 1'b0;
            reused      <= 1'b0;
            result      <= '0;
            ready       <= 1'b0;
        end else if (kill) begin
            ready       <= 1'b0;
            reuse_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (valid) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        op_q   <= mulop;
                        reused <= reuse_hit;
                    end
                end
                PREP: begin
                    neg   <= a_neg ^ b_neg;
                    acc   <= '0;
                    mcand <= {{XLEN{1'b0}}, a_abs};
                    mulr  <= b_abs;
                end
                CALC: begin
                    acc   <= acc + partial;
                    mcand <= mcand << BPC;
                    mulr  <= mulr_shift;
                end
                READY: begin
                    result      <= (op_q == OP_MUL) ? acc_signed[XLEN-1:0]
                                                    : acc_signed[2*XLEN-1:XLEN];
                    last_a      <= a_q;
                    last_b      <= b_q;
                    reuse_valid <= REUSE;
                    // The stored pair must describe acc, so a reused MUL keeps the pair it was computed with.
                    if (!reused) begin
                        last_sa <= op_sa;
                        last_sb <= op_sb;
                    end
                end
                DONE:    ready <= valid;
                default: ready <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_iter_param.sv
// tb_mul_iter_param: four multiplier configurations checked against a wide-arithmetic
// reference model for result, latency and handshake behaviour.
`default_nettype none

module tb_mul_iter_param;

    logic        clk = 1'b0;
    logic        resetn;
    logic        kill;
    logic [3:0]  valid;
    logic [1:0]  mulop;
    logic [63:0] op_a, op_b;
    logic [31:0] res0, res1, res2;
    logic [63:0] res3;
    logic [3:0]  rdy, bsy;

    int tests = 0;
    int fails = 0;

    int          m_xl  [4] = '{32, 32, 32, 64};
    int          m_bpc [4] = '{1, 2, 4, 1};
    logic        m_rv  [4];
    logic        m_sa  [4];
    logic        m_sb  [4];
    logic [63:0] m_la  [4];
    logic [63:0] m_lb  [4];
    logic [63:0] m_res [4];

    always #5 clk = ~clk;

    mul_iter_param #(.XLEN(32), .BPC(1), .REUSE_EN(1)) dut0 (
        .clk(clk), .resetn(resetn), .valid(valid[0]), .kill(kill), .mulop(mulop),
        .op_a(op_a[31:0]), .op_b(op_b[31:0]), .result(res0), .ready(rdy[0]), .busy(bsy[0]));
    mul_iter_param #(.XLEN(32), .BPC(2), .REUSE_EN(1)) dut1 (
        .clk(clk), .resetn(resetn), .valid(valid[1]), .kill(kill), .mulop(mulop),
        .op_a(op_a[31:0]), .op_b(op_b[31:0]), .result(res1), .ready(rdy[1]), .busy(bsy[1]));
    mul_iter_param #(.XLEN(32), .BPC(4), .REUSE_EN(1)) dut2 (
        .clk(clk), .resetn(resetn), .valid(valid[2]), .kill(kill), .mulop(mulop),
        .op_a(op_a[31:0]), .op_b(op_b[31:0]), .result(res2), .ready(rdy[2]), .busy(bsy[2]));
    mul_iter_param #(.XLEN(64), .BPC(1), .REUSE_EN(1)) dut3 (
        .clk(clk), .resetn(resetn), .valid(valid[3]), .kill(kill), .mulop(mulop),
        .op_a(op_a), .op_b(op_b), .result(res3), .ready(rdy[3]), .busy(bsy[3]));

    function automatic logic [63:0] get_res(input int sel);
        case (sel)
            0:       return {32'd0, res0};
            1:       return {32'd0, res1};
            2:       return {32'd0, res2};
            default: return res3;
        endcase
    endfunction

    function automatic logic [63:0] mask64(input int xl);
        return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Exact product of the sign-extended operands, then the requested half.
    function automatic logic [63:0] ref_res(input int xl, input logic [1:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] mask, ea, eb, p;
        logic sa, sb;
        mask = (128'd1 << xl) - 128'd1;
        sa = (op == 2'b01) || (op == 2'b10);
        sb = (op == 2'b01);
        ea = {64'd0, a} & mask;
        eb = {64'd0, b} & mask;
        if (sa && ea[xl-1]) ea = ea | ~mask;
        if (sb && eb[xl-1]) eb = eb | ~mask;
        p = ea * eb;
        if (op == 2'b00) return 64'(p & mask);
        return 64'((p >> xl) & mask);
    endfunction

    function automatic int ref_k(input int xl, input int bpc, input logic [1:0] op,
                                 input logic [63:0] b);
        logic [63:0] bm;
        int bl;
        bm = b & mask64(xl);
        if (op == 2'b01 && bm[xl-1]) bm = (~bm + 64'd1) & mask64(xl);
        bl = 0;
        for (int i = 0; i < xl; i++) if (bm[i]) bl = i + 1;
        return (bl + bpc - 1) / bpc;
    endfunction

    function automatic logic [63:0] pick(input int xl);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'd1 << (xl - 1);
            3:       v = 64'($urandom_range(0, 15));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask64(xl);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int sel, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input string tag);
        logic [63:0] am, bm, exp;
        logic sa, sb, reuse;
        int lat, lat_exp;
        am    = a & mask64(m_xl[sel]);
        bm    = b & mask64(m_xl[sel]);
        sa    = (op == 2'b01) || (op == 2'b10);
        sb    = (op == 2'b01);
        exp   = ref_res(m_xl[sel], op, am, bm);
        reuse = m_rv[sel] && am == m_la[sel] && bm == m_lb[sel] &&
                (op == 2'b00 || (sa == m_sa[sel] && sb == m_sb[sel]));
        lat_exp = reuse ? 2 : ref_k(m_xl[sel], m_bpc[sel], op, bm) + 3;

        mulop = op; op_a = am; op_b = bm; valid[sel] = 1'b1;
        lat = -1;
        for (int e = 0; e < 150; e++) begin
            @(posedge clk); #1;
            if (rdy[sel]) begin lat = e; break; end
        end
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_result"}, get_res(sel), exp);
        check({tag, "_busy_done"}, 64'(bsy[sel]), 64'd1);
        valid[sel] = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_drop"}, 64'(rdy[sel]), 64'd0);
        check({tag, "_busy_idle"}, 64'(bsy[sel]), 64'd0);

        if (!reuse) begin m_sa[sel] = sa; m_sb[sel] = sb; end
        m_rv[sel] = 1'b1; m_la[sel] = am; m_lb[sel] = bm; m_res[sel] = exp;
    endtask

    initial begin
        logic [63:0] ra, rb;
        resetn = 1'b0; kill = 1'b0; valid = 4'b0; mulop = 2'b00; op_a = '0; op_b = '0;
        for (int s = 0; s < 4; s++) begin
            m_rv[s] = 1'b0; m_sa[s] = 1'b0; m_sb[s] = 1'b0;
            m_la[s] = '0; m_lb[s] = '0; m_res[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            check("reset_result", get_res(s), 64'd0);
            check("reset_ready", 64'(rdy[s]), 64'd0);
            check("reset_busy", 64'(bsy[s]), 64'd0);
        end
        resetn = 1'b1;
        @(posedge clk); #1;

        run_op(0, 2'b00, 64'd3, 64'd5, "mul_3x5");
        run_op(1, 2'b01, 64'h8000_0000, 64'hFFFF_FFFF, "mulh_min_m1");
        run_op(1, 2'b00, 64'h8000_0000, 64'hFFFF_FFFF, "mul_reuse");
        run_op(2, 2'b10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhsu_m1");
        run_op(2, 2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhu_noreuse");
        run_op(0, 2'b00, 64'h1234_5678, 64'd0, "mul_b_zero");
        run_op(3, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "mulhu64_ones");

        // Kill mid-CALC: the unit idles, result keeps the prior value, reuse is dropped.
        mulop = 2'b00; op_a = 64'd7; op_b = 64'h8000_0000; valid[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("kill_busy_calc", 64'(bsy[0]), 64'd1);
        kill = 1'b1; valid[0] = 1'b0;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_ready", 64'(rdy[0]), 64'd0);
        check("kill_busy", 64'(bsy[0]), 64'd0);
        check("kill_result_kept", get_res(0), m_res[0]);
        m_rv[0] = 1'b0;
        run_op(0, 2'b00, 64'd7, 64'h8000_0000, "mul_after_kill");

        for (int s = 0; s < 4; s++) begin
            ra = pick(m_xl[s]);
            rb = pick(m_xl[s]);
            for (int n = 0; n < 15; n++) begin
                if ($urandom_range(0, 3) != 0) begin
                    ra = pick(m_xl[s]);
                    rb = pick(m_xl[s]);
                end
                run_op(s, 2'($urandom_range(0, 3)), ra, rb, "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
